// File: rtl/mem_stage_pkg.sv
// Shared encodings for the data-memory access stage: op codes, FSM states, access size.
// Also holds the alignment and load/store classification helpers used by the stage.
package mem_stage_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [1:0] ACCESS_WORD = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_REQ = 3'd1,
    ST_RD_CAP = 3'd2,
    ST_WR_REQ = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (op)
      OP_LW, OP_SW:         mis = (off != 2'b00);
      OP_LH, OP_LHU, OP_SH: mis = off[0];
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic is_load(input logic [2:0] op);
    return (op <= OP_LBU);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane logic: extracts/extends a loaded byte or halfword and merges store lanes.
// Purely combinational; offset 0 selects bits [31:24].
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] rd_word,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0:    byte_sel = rd_word[31:24];
      2'd1:    byte_sel = rd_word[23:16];
      2'd2:    byte_sel = rd_word[15:8];
      default: byte_sel = rd_word[7:0];
    endcase
    half_sel = offset[1] ? rd_word[15:0] : rd_word[31:16];
  end

  always_comb begin
    ld_data = rd_word;
    case (op)
      OP_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ld_data = {24'h000000, byte_sel};
      OP_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ld_data = {16'h0000, half_sel};
      default: ld_data = rd_word;
    endcase
  end

  always_comb begin
    merged = rd_word;
    if (op == OP_SB) begin
      case (offset)
        2'd0:    merged[31:24] = st_data[7:0];
        2'd1:    merged[23:16] = st_data[7:0];
        2'd2:    merged[15:8]  = st_data[7:0];
        default: merged[7:0]   = st_data[7:0];
      endcase
    end else if (op == OP_SH) begin
      if (offset[1]) merged[15:0]  = st_data[15:0];
      else           merged[31:16] = st_data[15:0];
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory access stage: one op in flight; loads 3 cycles, SW 2, SB/SH read-modify-write 4, faults 1.
// in_ready is high only in IDLE; upstream holds its op until then.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic [4:0]        dest_reg,
  output logic [ADDR_W-1:0] dm_address,
  output logic [DATA_W-1:0] dm_data_in,
  output logic [1:0]        dm_access_size,
  output logic              dm_rw,
  output logic              dm_enable,
  input  logic [DATA_W-1:0] dm_data_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_dest,
  output logic              out_wb_en,
  output logic              misalign
);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [4:0]        out_dest_q, out_dest_d;
  logic              out_wb_en_q, out_wb_en_d;
  logic              misalign_q, misalign_d;

  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] merged;

  // wdata_q carries the raw store data until RD_CAP replaces it with the merged word.
  mem_lane_align u_lane (
    .op      (op_q),
    .offset  (addr_q[1:0]),
    .rd_word (dm_data_out),
    .st_data (wdata_q),
    .ld_data (ld_data),
    .merged  (merged)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    out_data_d  = out_data_q;
    out_dest_d  = out_dest_q;
    out_wb_en_d = out_wb_en_q;
    misalign_d  = misalign_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d        = op;
          addr_d      = addr;
          wdata_d     = store_data;
          out_dest_d  = dest_reg;
          out_data_d  = '0;
          out_wb_en_d = 1'b0;
          misalign_d  = is_misaligned(op, addr[1:0]);
          if (is_misaligned(op, addr[1:0])) state_d = ST_DONE;
          else if (op == OP_SW)             state_d = ST_WR_REQ;
          else                              state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: state_d = ST_RD_CAP;
      ST_RD_CAP: begin
        if (is_load(op_q)) begin
          out_data_d  = ld_data;
          out_wb_en_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          wdata_d = merged;
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LW;
      addr_q      <= '0;
      wdata_q     <= '0;
      out_data_q  <= '0;
      out_dest_q  <= '0;
      out_wb_en_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      out_data_q  <= out_data_d;
      out_dest_q  <= out_dest_d;
      out_wb_en_q <= out_wb_en_d;
      misalign_q  <= misalign_d;
    end
  end

  // Strobes decode from state so an async reset drops them at once.
  assign in_ready       = (state_q == ST_IDLE);
  assign dm_enable      = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
  assign dm_rw          = (state_q != ST_WR_REQ);
  assign dm_address     = {addr_q[ADDR_W-1:2], 2'b00};
  assign dm_data_in     = wdata_q;
  assign dm_access_size = ACCESS_WORD;
  assign out_valid      = (state_q == ST_DONE);
  assign out_data       = out_data_q;
  assign out_dest       = out_dest_q;
  assign out_wb_en      = out_wb_en_q;
  assign misalign       = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage against a small word-addressed memory model.
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [4:0]  dest_reg = 5'd0;
  logic [31:0] dm_address;
  logic [31:0] dm_data_in;
  logic [1:0]  dm_access_size;
  logic        dm_rw;
  logic        dm_enable;
  logic [31:0] dm_data_out = 32'h0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_dest;
  logic        out_wb_en;
  logic        misalign;

  mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .addr(addr), .store_data(store_data), .dest_reg(dest_reg),
    .dm_address(dm_address), .dm_data_in(dm_data_in), .dm_access_size(dm_access_size),
    .dm_rw(dm_rw), .dm_enable(dm_enable), .dm_data_out(dm_data_out),
    .out_valid(out_valid), .out_data(out_data), .out_dest(out_dest),
    .out_wb_en(out_wb_en), .misalign(misalign)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [0:7];
  logic        loaded = 1'b0;
  always @(posedge clock) begin
    if (!loaded) begin
      mem[0] <= 32'h11223344;
      mem[1] <= 32'hFFFF8081;
      for (int i = 2; i < 8; i++) mem[i] <= 32'h0;
      loaded <= 1'b1;
    end else if (dm_enable) begin
      if (dm_rw) dm_data_out <= mem[dm_address[4:2]];
      else       mem[dm_address[4:2]] <= dm_data_in;
    end
  end

  int          checks = 0;
  int          failures = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wdata = 32'h0;
  logic [31:0] last_addr = 32'h0;

  always @(negedge clock) begin
    if (dm_enable) begin
      last_addr = dm_address;
      if (dm_rw) rd_cnt++;
      else begin
        wr_cnt++;
        last_wdata = dm_data_in;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] d, output int lat, output int nrd, output int nwr,
                        output logic rdy1);
    int rd0, wr0;
    @(negedge clock);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    in_valid = 1'b1; op = o; addr = a; store_data = sd; dest_reg = d;
    @(posedge clock);
    #1 in_valid = 1'b0;
    lat = 0;
    rdy1 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (c == 1) rdy1 = in_ready;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    nrd = rd_cnt - rd0;
    nwr = wr_cnt - wr0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [4:0] d, input logic [31:0] exp);
    int lat, nrd, nwr;
    logic rdy1;
    run_op(o, a, 32'h0, d, lat, nrd, nwr, rdy1);
    check_eq({tag, "_lat"}, lat, 32'd3);
    check_eq({tag, "_data"}, out_data, exp);
    check_eq({tag, "_wb"}, {31'd0, out_wb_en}, 32'd1);
    check_eq({tag, "_mis"}, {31'd0, misalign}, 32'd0);
    check_eq({tag, "_dest"}, {27'd0, out_dest}, {27'd0, d});
    check_eq({tag, "_rdwr"}, {nrd[15:0], nwr[15:0]}, {16'd1, 16'd0});
    check_eq({tag, "_busy"}, {31'd0, rdy1}, 32'd0);
  endtask

  initial begin
    int   lat, nrd, nwr, wr0;
    logic rdy1;

    repeat (3) @(negedge clock);
    check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_en", {31'd0, dm_enable}, 32'd0);
    check_eq("rst_rw", {31'd0, dm_rw}, 32'd1);
    check_eq("rst_addr", dm_address, 32'h0);
    check_eq("rst_din", dm_data_in, 32'h0);
    check_eq("rst_size", {30'd0, dm_access_size}, 32'd0);
    check_eq("rst_outs", {27'd0, out_valid, out_wb_en, misalign, 2'b00}, 32'd0);
    check_eq("rst_data", out_data, 32'h0);
    reset = 1'b0;

    do_load("lb1",  OP_LB,  32'h80020001, 5'd1, 32'h00000022);
    check_eq("lb1_addr", last_addr, 32'h80020000);
    do_load("lb7",  OP_LB,  32'h80020007, 5'd2, 32'hFFFFFF81);
    check_eq("lb7_addr", last_addr, 32'h80020004);
    do_load("lbu7", OP_LBU, 32'h80020007, 5'd3, 32'h00000081);
    do_load("lh6",  OP_LH,  32'h80020006, 5'd4, 32'hFFFF8081);
    do_load("lhu6", OP_LHU, 32'h80020006, 5'd5, 32'h00008081);
    do_load("lw0",  OP_LW,  32'h80020000, 5'd6, 32'h11223344);

    run_op(OP_SB, 32'h80020003, 32'h000000AB, 5'd9, lat, nrd, nwr, rdy1);
    check_eq("sb_lat", lat, 32'd4);
    check_eq("sb_rdwr", {nrd[15:0], nwr[15:0]}, {16'd1, 16'd1});
    check_eq("sb_wdata", last_wdata, 32'h112233AB);
    check_eq("sb_wb", {31'd0, out_wb_en}, 32'd0);
    check_eq("sb_data", out_data, 32'h0);
    check_eq("sb_mem", mem[0], 32'h112233AB);

    run_op(OP_SW, 32'h80020000, 32'hDEADBEEF, 5'd10, lat, nrd, nwr, rdy1);
    check_eq("sw_lat", lat, 32'd2);
    check_eq("sw_rdwr", {nrd[15:0], nwr[15:0]}, {16'd0, 16'd1});
    check_eq("sw_wdata", last_wdata, 32'hDEADBEEF);
    check_eq("sw_wb", {31'd0, out_wb_en}, 32'd0);
    do_load("lw_sw", OP_LW, 32'h80020000, 5'd11, 32'hDEADBEEF);

    run_op(OP_LW, 32'h80020002, 32'h0, 5'd12, lat, nrd, nwr, rdy1);
    check_eq("mis_lat", lat, 32'd1);
    check_eq("mis_rdwr", {nrd[15:0], nwr[15:0]}, 32'd0);
    check_eq("mis_flag", {31'd0, misalign}, 32'd1);
    check_eq("mis_wb", {31'd0, out_wb_en}, 32'd0);
    check_eq("mis_data", out_data, 32'h0);
    check_eq("mis_dest", {27'd0, out_dest}, 32'd12);
    @(negedge clock);
    check_eq("hold_flag", {30'd0, out_valid, misalign}, 32'd1);

    // Abort a halfword read-modify-write while the read data is being captured.
    @(negedge clock);
    wr0 = wr_cnt;
    in_valid = 1'b1; op = OP_SH; addr = 32'h80020006; store_data = 32'h00005555; dest_reg = 5'd3;
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    check_eq("sh_rdreq", {30'd0, dm_enable, dm_rw}, 32'd3);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("abort_en", {31'd0, dm_enable}, 32'd0);
    check_eq("abort_rdy", {30'd0, in_ready, dm_rw}, 32'd3);
    check_eq("abort_addr", dm_address, 32'h0);
    check_eq("abort_din", dm_data_in, 32'h0);
    check_eq("abort_outs", {26'd0, out_dest, out_valid}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check_eq("abort_nowr", wr_cnt - wr0, 32'd0);
    check_eq("abort_mem", mem[1], 32'hFFFF8081);
    check_eq("abort_idle", {30'd0, in_ready, out_valid}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
